cnn_global_avgp: RTL

CNN_GLOBAL_AVGP -- requirements
Module: cnn_global_avgp

---
 rtl/cnn_global_avgp_pkg.sv | 26 ++
 rtl/cnn_global_avgp_acc_ram.sv | 33 +++
 rtl/cnn_global_avgp.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cnn_global_avgp_pkg.sv
// Shared parameter helpers for the global average pool: log2 and the check that
// the frame size is a power of two.
package cnn_global_avgp_pkg;

    function automatic int clog2(input int unsigned value);
        int result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Accumulator width grows by log2(positions) so a full-frame sum never overflows.
    function automatic int acc_width(input int data_width, input int image_size);
        return data_width + clog2(image_size);
    endfunction

endpackage

// File: rtl/cnn_global_avgp_acc_ram.sv
// Per-channel accumulator store: synchronous read, synchronous write, one entry
// per channel, written in a form that maps onto block RAM.
module global_avgp_acc_ram
    import cnn_global_avgp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_global_avgp.sv
// Global average pooling over a channel-interleaved feature-map stream: one
// rounded average per channel, emitted as the frame's last position arrives.
module cnn_global_avgp
    import cnn_global_avgp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int SHIFT      = clog2(IMAGE_SIZE);
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, IMAGE_SIZE);
    localparam int CH_W       = clog2(CHANNEL_NUM);
    localparam int POS_W      = (SHIFT > 0) ? SHIFT : 1;
    localparam logic [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'((1 << SHIFT) >> 1);

    if (!is_pow2(IMAGE_SIZE) || CHANNEL_NUM < 4) begin : g_param_check
        $error("cnn_global_avgp: IMAGE_WIDTH*IMAGE_HEIGHT must be a power of two and CHANNEL_NUM >= 4");
    end

    logic [CH_W-1:0]       ch_cnt_q, ch_cnt_d;
    logic [POS_W-1:0]      pos_cnt_q, pos_cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_pxl_q, s1_pxl_d;
    logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [ACC_WIDTH-1:0]        acc_rd;
    logic signed [ACC_WIDTH-1:0] pxl_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] rounded;
    logic                        ch_last;
    logic                        pos_last;

    always_comb begin
        ch_cnt_d     = ch_cnt_q;
        pos_cnt_d    = pos_cnt_q;
        s1_valid_d   = valid_in;
        s1_pxl_d     = s1_pxl_q;
        s1_ch_d      = s1_ch_q;
        s1_first_d   = s1_first_q;
        s1_last_d    = s1_last_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;

        ch_last  = (ch_cnt_q == CH_W'(CHANNEL_NUM - 1));
        pos_last = (pos_cnt_q == POS_W'(IMAGE_SIZE - 1));

        // Stage 1: capture the word and its position flags; the RAM read runs in parallel.
        if (valid_in) begin
            s1_pxl_d   = pxl_in;
            s1_ch_d    = ch_cnt_q;
            s1_first_d = (pos_cnt_q == '0);
            s1_last_d  = pos_last;
            ch_cnt_d   = ch_last ? '0 : ch_cnt_q + 1'b1;
            if (ch_last) begin
                pos_cnt_d = pos_last ? '0 : pos_cnt_q + 1'b1;
            end
        end

        // Stage 2: position 0 overwrites the stale accumulator instead of adding to it.
        pxl_ext = ACC_WIDTH'($signed(s1_pxl_q));
        sum     = s1_first_q ? pxl_ext : $signed(acc_rd) + pxl_ext;
        rounded = sum + $signed(ROUND);

        if (s1_valid_q && s1_last_q) begin
            valid_out_d  = 1'b1;
            frame_done_d = (s1_ch_q == CH_W'(CHANNEL_NUM - 1));
            pxl_out_d    = DATA_WIDTH'(rounded >>> SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_cnt_q     <= '0;
            pos_cnt_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_pxl_q     <= '0;
            s1_ch_q      <= '0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ch_cnt_q     <= ch_cnt_d;
            pos_cnt_q    <= pos_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_pxl_q     <= s1_pxl_d;
            s1_ch_q      <= s1_ch_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read and write never hit the same channel: consecutive words differ in channel.
    global_avgp_acc_ram #(
        .DEPTH      (CHANNEL_NUM),
        .WIDTH      (ACC_WIDTH),
        .ADDR_WIDTH (CH_W)
    ) u_acc_ram (
        .clk     (clk),
        .rd_en   (valid_in),
        .rd_addr (ch_cnt_q),
        .rd_data (acc_rd),
        .wr_en   (s1_valid_q),
        .wr_addr (s1_ch_q),
        .wr_data (sum)
    );

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
